desc_patch_fetch: RTL and testbench
===================================

# desc_patch_fetch

Upstream feeder for the `ncc` descriptor stage. It watches the raster pixel stream of a frame and captures the 8x8 patch at a requested origin. It packs the patch into 16 words of four 8-bit pixels and presents each word on the `desc_data_ready`/`desc_data_out` pair that drives `ncc`'s `desc_data_ready`/`desc_data_in` inputs. There is no backpressure; `ncc` takes every strobed word.

## Interface
- `IMG_W`, 640: frame width in pixels (≥ 8).
- `IMG_H`, 480: frame height in pixels (≥ 8).
- `XW`, 10: width of column coordinates/counters; must satisfy 2^XW ≥ IMG_W.
- `YW`, 10: width of row coordinates/counters; must satisfy 2^YW ≥ IMG_H.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a patch capture; sampled only in IDLE.
- `win_x` in XW: patch origin column (left edge), sampled with `start`.
- `win_y` in YW: patch origin row (top edge), sampled with `start`.
- `pix_valid` in 1: pixel qualifier.
- `pix_sof` in 1: first pixel of frame, pixel (0,0); meaningful only with `pix_valid`.
- `pix_data` in 8: pixel value.
- `desc_data_ready` out 1: one-cycle strobe; `desc_data_out` holds a new word.
- `desc_data_out` out 32: four pixels, left to right in bits [31:24], [23:16], [15:8], [7:0].
- `busy` out 1: high in ARMED or CAPTURE.
- `done` out 1: one-cycle pulse, coincident with the 16th strobe.
- `err` out 1: one-cycle pulse on rejected origin or aborted capture.

## Operation
States: IDLE, ARMED, CAPTURE.

- **IDLE**
  - `start`=1: latch origin (see Configuration) and go to ARMED.
  - Otherwise remain in IDLE.
- **ARMED**
  - `start` is ignored.
  - On `pix_valid && pix_sof`: set col=0, row=0, word count=0, lane count=0, and go to CAPTURE.
  - The sof pixel itself is processed as pixel (0,0).
- **CAPTURE**, on each `pix_valid` pixel at (col,row):
  - If win_x ≤ col ≤ win_x+7 and win_y ≤ row ≤ win_y+7, shift `pix_data` into the pack register. The first pixel of a group lands in [31:24].
  - Lane count increments on each captured pixel. On the 4th lane, the packed word is registered to `desc_data_out`, `desc_data_ready` is raised for one cycle, word count increments, and lane count returns to 0.
  - col increments per valid pixel. At col=IMG_W-1, col wraps to 0 and row increments.
  - Each patch row produces exactly 2 words. Word order is row-major: word 2r is columns 0–3 of patch row r; word 2r+1 is columns 4–7.
  - After the 16th word: `done`=1 together with the strobe, then go to IDLE.
- **sof while in CAPTURE** (`pix_valid && pix_sof`):
  - Discard the partial patch; `err` pulses.
  - Counters restart with this pixel as (0,0), and the capture restarts in CAPTURE with the same origin.
  - Words already emitted are not retracted; `ncc` must be reset by its owner.
- **Non-valid cycles** (`pix_valid`=0): no state change. A `pix_sof` with `pix_valid`=0 is ignored.
- **Output holding:** `desc_data_out` holds its last value between strobes.
- **Reset:** state IDLE, all counters 0. Output reset values: `desc_data_out`=0, `desc_data_ready`=0, `busy`=0, `done`=0, `err`=0. Reset mid-capture behaves identically.

## Timing
- Strobe latency: `desc_data_ready` rises one cycle after the cycle in which the 4th pixel of a group is valid.
- `done` is coincident with the last strobe. `busy` falls the cycle after `done`.
- `busy` rises the cycle after `start` is accepted.
- Strobes are never back-to-back closer than 4 valid pixels apart.
- Throughput: one pixel per cycle, with arbitrary `pix_valid` gaps.
- `err` for origin rejection: one cycle after `start`.
- `err` for sof abort: one cycle after the sof pixel.

## Configuration
- Macro: `DESC_ORIGIN_CHECK_EN`.
- **Defined:** at `start`, the origin is rejected if win_x > IMG_W-8 or win_y > IMG_H-8.
  - On rejection: `err` pulses, state stays IDLE, `busy` stays 0, and no strobes are issued.
  - In-range origins are latched unchanged.
- **Undefined:** no `err` on origin. The origin is clamped and the capture always proceeds:
  - win_x is latched as min(win_x, IMG_W-8).
  - win_y is latched as min(win_y, IMG_H-8).

## Test plan
All tests use IMG_W=16, IMG_H=16 and pixel value = (row*16+col) & 0xFF.

- **Basic capture:** origin (0,0), continuous valid -> 16 strobes.
  - word0=0x00010203, word1=0x04050607, word2=0x10111213, word15=0x74757677.
  - `done` is coincident with the 16th strobe; `busy` is 0 the next cycle.
- **Gapped input:** origin (8,8), `pix_valid` toggling every cycle -> word0=0x88898A8B, word15=0xFCFDFEFF.
  - Each strobe is exactly one cycle after its 4th valid pixel.
- **ARMED behaviour:** `start` in IDLE, then a second `start` while ARMED, then sof 5 cycles later.
  - Capture begins only at sof, and the second `start` has no effect.
  - `busy`=1 from the cycle after the first `start`.
- **Out-of-range origin** (12,3):
  - With the macro: `err`=1 one cycle after `start`, `busy`=0, zero strobes.
  - Without the macro: word0=0x38393A3B (clamped to x=8).
- **sof abort:** sof arrives after 5 words of a capture at origin (0,0) -> `err` pulse, then 16 fresh words starting 0x00010203, with `done` on the last one.
- **Reset mid-capture:** `rst` asserted after word 3 -> next cycle all outputs are 0 and state is IDLE; subsequent sof pixels produce no strobes.

Source files
------------

// File: rtl/desc_patch_fetch.sv
// desc_patch_fetch: watches a raster pixel stream, captures the 8x8 patch at a
// requested origin and emits it as 16 packed 32-bit words (row-major, two words
// per patch row, leftmost pixel in [31:24]).
// Optional build macro: DESC_ORIGIN_CHECK_EN. When defined, out-of-range origins
// are rejected with an err pulse; when undefined, the origin is clamped so the
// patch always fits inside the frame.
module desc_patch_fetch #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int XW    = 10,
   parameter int YW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [XW-1:0] win_x,
   input  logic [YW-1:0] win_y,
   input  logic          pix_valid,
   input  logic          pix_sof,
   input  logic [7:0]    pix_data,
   output logic          desc_data_ready,
   output logic [31:0]   desc_data_out,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

   localparam logic [XW-1:0] MAX_X    = XW'(IMG_W - 8);
   localparam logic [YW-1:0] MAX_Y    = YW'(IMG_H - 8);
   localparam logic [XW-1:0] LAST_COL = XW'(IMG_W - 1);

   state_t        state, state_nx;
   logic [XW-1:0] org_x, org_x_nx, col, col_nx;
   logic [YW-1:0] org_y, org_y_nx, row, row_nx;
   logic [1:0]    lane, lane_nx;
   logic [3:0]    wcnt, wcnt_nx;
   logic [23:0]   pack, pack_nx;
   logic [31:0]   dout_nx;
   logic          ready_nx, done_nx, err_nx;

   // Working copies of the position/counters for the current pixel; a sof
   // pixel forces them to the frame origin before the window test.
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic [1:0]    lane_e;
   logic [3:0]    wcnt_e;
   logic          in_win;
   logic [31:0]   pix_word;

   // busy covers the done cycle so it drops only on the cycle after done.
   assign busy = (state != S_IDLE) || done;

   // Register stage: FSM state, capture counters and the strobed outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values computed by the combinational block.
      if (rst) begin
         state           <= S_IDLE;
         org_x           <= '0;
         org_y           <= '0;
         col             <= '0;
         row             <= '0;
         lane            <= '0;
         wcnt            <= '0;
         pack            <= '0;
         desc_data_out   <= '0;
         desc_data_ready <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
      end else begin
         state           <= state_nx;
         org_x           <= org_x_nx;
         org_y           <= org_y_nx;
         col             <= col_nx;
         row             <= row_nx;
         lane            <= lane_nx;
         wcnt            <= wcnt_nx;
         pack            <= pack_nx;
         desc_data_out   <= dout_nx;
         desc_data_ready <= ready_nx;
         done            <= done_nx;
         err             <= err_nx;
      end
   end

   // Next-state and datapath: origin latch, raster tracking, pixel packing.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_nx = state;
      org_x_nx = org_x;
      org_y_nx = org_y;
      col_nx   = col;
      row_nx   = row;
      lane_nx  = lane;
      wcnt_nx  = wcnt;
      pack_nx  = pack;
      dout_nx  = desc_data_out;
      ready_nx = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      cx       = col;
      cy       = row;
      lane_e   = lane;
      wcnt_e   = wcnt;
      in_win   = 1'b0;
      pix_word = {pack, pix_data};

      case (state)
         S_IDLE: begin
            if (start) begin
`ifdef DESC_ORIGIN_CHECK_EN
               if ((win_x > MAX_X) || (win_y > MAX_Y)) begin
                  err_nx = 1'b1;
               end else begin
                  org_x_nx = win_x;
                  org_y_nx = win_y;
                  state_nx = S_ARMED;
               end
`else
               org_x_nx = (win_x > MAX_X) ? MAX_X : win_x;
               org_y_nx = (win_y > MAX_Y) ? MAX_Y : win_y;
               state_nx = S_ARMED;
`endif
            end
         end

         S_ARMED, S_CAPTURE: begin
            if (pix_valid && ((state == S_CAPTURE) || pix_sof)) begin
               if (pix_sof) begin
                  // sof restarts the patch; inside CAPTURE it is an abort.
                  cx       = '0;
                  cy       = '0;
                  lane_e   = '0;
                  wcnt_e   = '0;
                  err_nx   = (state == S_CAPTURE);
                  state_nx = S_CAPTURE;
               end

               in_win = (cx >= org_x) && (cx <= org_x + XW'(7)) &&
                        (cy >= org_y) && (cy <= org_y + YW'(7));

               if (cx == LAST_COL) begin
                  col_nx = '0;
                  row_nx = cy + YW'(1);
               end else begin
                  col_nx = cx + XW'(1);
                  row_nx = cy;
               end

               lane_nx = lane_e;
               wcnt_nx = wcnt_e;
               if (in_win) begin
                  pack_nx = pix_word[23:0];
                  lane_nx = lane_e + 2'd1;
                  if (lane_e == 2'd3) begin
                     dout_nx  = pix_word;
                     ready_nx = 1'b1;
                     wcnt_nx  = wcnt_e + 4'd1;
                     if (wcnt_e == 4'd15) begin
                        done_nx  = 1'b1;
                        state_nx = S_IDLE;
                     end
                  end
               end
            end
         end

         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_desc_patch_fetch.sv
// Scoreboard bench for desc_patch_fetch on a 16x16 frame. The stimulus side
// computes expected words directly from patch coordinates and frame contents;
// a monitor pops and compares whenever the DUT strobes a word or an error.
module tb_desc_patch_fetch;

   localparam int W  = 16;
   localparam int H  = 16;
   localparam int XW = 5;
   localparam int YW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [XW-1:0] win_x = '0;
   logic [YW-1:0] win_y = '0;
   logic          pix_valid = 1'b0;
   logic          pix_sof = 1'b0;
   logic [7:0]    pix_data = '0;
   logic          desc_data_ready;
   logic [31:0]   desc_data_out;
   logic          busy, done, err;

   desc_patch_fetch #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
      .clk(clk), .rst(rst), .start(start), .win_x(win_x), .win_y(win_y),
      .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
      .desc_data_ready(desc_data_ready), .desc_data_out(desc_data_out),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          is_err;
      logic [31:0] data;
      bit          last;
      int          at;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] frame [H][W];

   // Reference model state: latched origin and progress of the live capture.
   int ox, oy, m_words;
   bit m_armed, m_active;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input bit is_err, input logic [31:0] data, input bit last);
      ev_t e;
      e.is_err = is_err;
      e.data   = data;
      e.last   = last;
      e.at     = cyc + 1;
      exp_q.push_back(e);
   endtask

   // Monitor: samples just after each active edge and scores DUT events.
   bit chk_idle = 1'b0;
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         if (chk_idle) begin
            check("busy_after_done", 32'(busy), 32'd0);
            chk_idle = 1'b0;
         end
         if (err) begin
            if (exp_q.size() == 0) check("unexpected_err", 32'(err), 32'd0);
            else begin
               e = exp_q.pop_front();
               check("err_expected_here", 32'(e.is_err), 32'd1);
               check("err_cycle", 32'(cyc), 32'(e.at));
            end
         end
         if (desc_data_ready) begin
            if (exp_q.size() == 0) check("unexpected_strobe", 32'(desc_data_ready), 32'd0);
            else begin
               e = exp_q.pop_front();
               check("strobe_expected_here", 32'(e.is_err), 32'd0);
               check("word_data", desc_data_out, e.data);
               check("strobe_cycle", 32'(cyc), 32'(e.at));
               check("done_flag", 32'(done), 32'(e.last));
               if (e.last) begin
                  check("busy_in_done_cycle", 32'(busy), 32'd1);
                  chk_idle = 1'b1;
               end
            end
         end else if (done) begin
            check("done_without_strobe", 32'(done), 32'd0);
         end
      end
   end

   // Model of one valid pixel at real frame coordinates (c,r).
   task automatic model_pixel(input int c, input int r, input bit sof);
      if (sof && (m_armed || m_active)) begin
         if (m_active) push_ev(1'b1, '0, 1'b0);
         m_active = 1'b1;
         m_armed  = 1'b0;
         m_words  = 0;
      end
      if (m_active && c >= ox && c <= ox + 7 && r >= oy && r <= oy + 7 && ((c - ox) % 4 == 3)) begin
         m_words++;
         push_ev(1'b0, {frame[r][c-3], frame[r][c-2], frame[r][c-1], frame[r][c]}, m_words == 16);
         if (m_words == 16) m_active = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         start     = 1'b0;
         pix_valid = 1'b0;
         pix_sof   = 1'b0;
      end
   endtask

   task automatic drive_pix(input int c, input int r, input bit sof);
      @(negedge clk);
      start     = 1'b0;
      pix_valid = 1'b1;
      pix_sof   = sof;
      pix_data  = frame[r][c];
      model_pixel(c, r, sof);
   endtask

   task automatic do_start(input int x, input int y);
      bit exp_busy;
      @(negedge clk);
      start     = 1'b1;
      win_x     = XW'(x);
      win_y     = YW'(y);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      exp_busy  = 1'b1;
      if (!m_armed && !m_active) begin
`ifdef DESC_ORIGIN_CHECK_EN
         if (x > W - 8 || y > H - 8) begin
            push_ev(1'b1, '0, 1'b0);
            exp_busy = 1'b0;
         end else begin
            ox = x;
            oy = y;
            m_armed = 1'b1;
         end
`else
         ox = (x > W - 8) ? W - 8 : x;
         oy = (y > H - 8) ? H - 8 : y;
         m_armed = 1'b1;
`endif
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'(exp_busy));
   endtask

   // gap_mode: 0 continuous, 1 idle cycle before every pixel, 2 random gaps
   // (gap cycles carry a stray sof with pix_valid low, which must be ignored).
   task automatic send_frame(input int gap_mode, input int stop_words);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (gap_mode == 1) idle(1);
            else if (gap_mode == 2) begin
               while ($urandom_range(0, 2) == 0) begin
                  @(negedge clk);
                  pix_valid = 1'b0;
                  pix_sof   = 1'($urandom_range(0, 1));
               end
            end
            drive_pix(c, r, (r == 0) && (c == 0));
            if (m_words >= stop_words && m_active) begin
               idle(1);
               return;
            end
         end
      end
      idle(1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending_events", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      idle(2);
   endtask

   task automatic fill_formula();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) frame[r][c] = 8'((r * 16 + c) & 8'hFF);
   endtask

   task automatic fill_random();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) frame[r][c] = 8'($urandom_range(0, 255));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},  desc_data_out, 32'd0);
      check({tag, "_ready"}, 32'(desc_data_ready), 32'd0);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      check({tag, "_err"},   32'(err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_armed  = 1'b0;
      m_active = 1'b0;
      m_words  = 0;
      ox = 0;
      oy = 0;
      fill_formula();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      // Basic capture, continuous pixels.
      do_start(0, 0);
      send_frame(0, 99);
      drain();

      // Gapped input at the bottom-right corner of the frame.
      do_start(8, 8);
      send_frame(1, 99);
      drain();

      // ARMED: a second start is ignored, stray pixels before sof ignored.
      do_start(2, 5);
      do_start(9, 1);
      drive_pix(3, 3, 1'b0);
      drive_pix(4, 3, 1'b0);
      drive_pix(5, 3, 1'b0);
      send_frame(0, 99);
      drain();

      // Out-of-range origin: rejected or clamped depending on the build.
      do_start(12, 3);
      send_frame(0, 99);
      drain();

      // sof abort after 5 words, then a full fresh capture.
      do_start(0, 0);
      send_frame(0, 5);
      send_frame(0, 99);
      drain();

      // Reset in the middle of a capture; later frames produce nothing.
      do_start(0, 0);
      send_frame(0, 3);
      drain();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_armed  = 1'b0;
      m_active = 1'b0;
      check_all_zero("after_mid_reset");
      send_frame(0, 99);
      drain();

      // Randomized origins (some out of range), data and gaps.
      for (int i = 0; i < 8; i++) begin
         fill_random();
         do_start($urandom_range(0, 20), $urandom_range(0, 20));
         send_frame(2, 99);
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
